// File: rtl/stim_pkg.sv
// Shared definitions for the LCG stimulus generator: FSM states, generation
// modes and the LCG constants.
package stim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FILL    = 2'd1,
        ST_PRESENT = 2'd2,
        ST_DONE    = 2'd3
    } stim_state_e;

    // Mode 3 is not listed on purpose: anything that is not INCR or WALK behaves as RANDOM.
    localparam logic [1:0] MODE_RANDOM = 2'd0;
    localparam logic [1:0] MODE_INCR   = 2'd1;
    localparam logic [1:0] MODE_WALK   = 2'd2;

    localparam logic [31:0] LCG_MULT = 32'h41C64E6D;
    localparam logic [31:0] LCG_INC  = 32'h0000_3039;

    function automatic int nwords(input int width);
        return (width + 31) / 32;
    endfunction

endpackage

// File: rtl/lcg_step.sv
// Combinational next-state for the 32-bit generator state: +1 in INCR mode,
// otherwise one LCG step modulo 2^32.
module lcg_step
    import stim_pkg::*;
(
    input  logic [31:0] state_i,
    input  logic [1:0]  mode_i,
    output logic [31:0] next_o
);

    always_comb begin
        if (mode_i == MODE_INCR) begin
            next_o = state_i + 32'd1;
        end else begin
            next_o = state_i * LCG_MULT + LCG_INC;
        end
    end

endmodule

// File: rtl/lcg_stim_gen.sv
// Stimulus vector generator: assembles OUT_W-bit vectors one 32-bit word per
// FILL cycle and presents them on a valid/ready port.
module lcg_stim_gen
    import stim_pkg::*;
#(
    parameter int          OUT_W        = 139,
    parameter int          CNT_W        = 16,
    parameter logic [31:0] SEED_DEFAULT = 32'd2430986565
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_load,
    input  logic [31:0]      seed_in,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vec,
    input  logic [1:0]       mode,
    output logic [OUT_W-1:0] vec_out,
    output logic             vec_valid,
    input  logic             vec_ready,
    output logic [CNT_W-1:0] vec_idx,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state_dbg
);

    localparam int NWORDS = nwords(OUT_W);
    localparam int WORD_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    stim_state_e      state_q, state_d;
    logic [31:0]      lcg_q, lcg_d;
    logic [OUT_W-1:0] vec_q, vec_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [1:0]       mode_q, mode_d;
    logic [WORD_W-1:0] word_q, word_d;

    logic [31:0]      lcg_next;
    logic [31:0]      word_sh;
    logic [31:0]      walk_pos;
    logic [OUT_W-1:0] word_mask;
    logic [OUT_W-1:0] word_data;
    logic [OUT_W-1:0] walk_vec;

    lcg_step u_lcg_step (
        .state_i (lcg_q),
        .mode_i  (mode_q),
        .next_o  (lcg_next)
    );

    // Place the fresh word at bit 32*word_q; shifts past OUT_W drop the excess bits.
    always_comb begin
        word_sh   = 32'(word_q) << 5;
        word_mask = ({OUT_W{1'b1}} << word_sh) & ~({OUT_W{1'b1}} << (word_sh + 32'd32));
        word_data = OUT_W'({{OUT_W{1'b0}}, lcg_next} << word_sh);
        walk_pos  = 32'(idx_q) % 32'(OUT_W);
        walk_vec  = OUT_W'(1) << walk_pos;
    end

    // Valid/ready: vec_valid is high only in PRESENT; vec_out and vec_idx hold
    // until a cycle with vec_valid && vec_ready, which is the single transfer.
    always_comb begin
        state_d = state_q;
        lcg_d   = lcg_q;
        vec_d   = vec_q;
        idx_d   = idx_q;
        num_d   = num_q;
        mode_d  = mode_q;
        word_d  = word_q;
        case (state_q)
            ST_IDLE: begin
                if (seed_load) begin
                    lcg_d = seed_in;
                end
                if (start) begin
                    num_d   = num_vec;
                    mode_d  = mode;
                    idx_d   = '0;
                    word_d  = '0;
                    state_d = (num_vec == '0) ? ST_DONE : ST_FILL;
                end
            end
            ST_FILL: begin
                if (mode_q == MODE_WALK) begin
                    vec_d = walk_vec;
                end else begin
                    lcg_d = lcg_next;
                    vec_d = (vec_q & ~word_mask) | (word_data & word_mask);
                end
                if (int'(word_q) == NWORDS - 1) begin
                    state_d = ST_PRESENT;
                end else begin
                    word_d = word_q + 1'b1;
                end
            end
            ST_PRESENT: begin
                if (vec_ready) begin
                    if (idx_q == num_q - 1'b1) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        word_d  = '0;
                        state_d = ST_FILL;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            lcg_q   <= SEED_DEFAULT;
            vec_q   <= '0;
            idx_q   <= '0;
            num_q   <= '0;
            mode_q  <= MODE_RANDOM;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            lcg_q   <= lcg_d;
            vec_q   <= vec_d;
            idx_q   <= idx_d;
            num_q   <= num_d;
            mode_q  <= mode_d;
            word_q  <= word_d;
        end
    end

    assign vec_out   = vec_q;
    assign vec_idx   = idx_q;
    assign vec_valid = (state_q == ST_PRESENT);
    assign busy      = (state_q == ST_FILL) || (state_q == ST_PRESENT);
    assign done      = (state_q == ST_DONE);
    assign state_dbg = state_q;

endmodule
